// File: rtl/multicycle_control.sv
// Multicycle controller: fetch/decode/exec/mem/writeback sequencing for a
// small ARM-like ISA. Decoded datapath controls are latched when the fetch
// completes and stay stable until the next fetch completes. Phase strobes
// are decoded from the state register plus the ready inputs.
module multicycle_control #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               zero,
  output logic               imem_req,
  output logic               ir_write,
  output logic               Reg2Loc,
  output logic               Uncondbranch,
  output logic               Branch,
  output logic               MemtoReg,
  output logic               ALUSrc,
  output logic               MOVKop,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               pc_write,
  output logic               illegal,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired_count,
  output logic [2:0]         state
);

  localparam int unsigned OP_W   = 11;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  // Instruction class selects the path through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    K_ILL = 3'd0,
    K_ALU = 3'd1,
    K_BR  = 3'd2,
    K_LD  = 3'd3,
    K_ST  = 3'd4
  } kind_t;

  typedef struct packed {
    kind_t              kind;
    logic               reg2loc;
    logic               uncond;
    logic               branch;
    logic               memtoreg;
    logic               alusrc;
    logic               movkop;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               wait_hit_c;
  logic               unused_instr;

  // Only the opcode field steers control; operand bits belong to the datapath.
  assign unused_instr = ^instr_in[INSTR_W-OP_W-1:0];

  // Opcode decode into the registered control bundle.
  function automatic ctrl_t decode(input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    c.kind = K_ILL;
    casez (op)
      11'b000101?????: begin c.kind = K_BR;  c.uncond = 1'b1; c.aluop = ALUOP_W'(4'b0000); end
      11'b10001010000: begin c.kind = K_ALU; c.aluop = ALUOP_W'(4'b0000); end
      11'b10001011000: begin c.kind = K_ALU; c.aluop = ALUOP_W'(4'b0010); end
      11'b10101010000: begin c.kind = K_ALU; c.aluop = ALUOP_W'(4'b0001); end
      11'b10110100???: begin c.kind = K_BR;  c.branch = 1'b1; c.reg2loc = 1'b1;
                             c.aluop = ALUOP_W'(4'b0111); end
      11'b11001011000: begin c.kind = K_ALU; c.aluop = ALUOP_W'(4'b0110); end
      11'b111100101??: begin c.kind = K_ALU; c.movkop = 1'b1; c.alusrc = 1'b1;
                             c.aluop = ALUOP_W'(4'b1000); end
      11'b11111000000: begin c.kind = K_ST;  c.reg2loc = 1'b1; c.alusrc = 1'b1;
                             c.aluop = ALUOP_W'(4'b0010); end
      11'b11111000010: begin c.kind = K_LD;  c.memtoreg = 1'b1; c.alusrc = 1'b1;
                             c.aluop = ALUOP_W'(4'b0010); end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_hit_c = (wait_q == WAIT_W'(TIMEOUT));

  // Next state, strobes, wait counter and retire counter.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    wait_d    = '0;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    pc_write  = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      DECODE: begin
        if (ctrl_q.kind == K_ILL) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (ctrl_q.kind)
          K_LD, K_ST: state_d = MEM;
          K_BR: begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          if (ctrl_q.kind == K_LD) begin
            MemRead = 1'b1;
            state_d = WB;
          end else begin
            MemWrite = 1'b1;
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        end else if (wait_hit_c) begin
          bus_err = 1'b1;
          state_d = FETCH;
        end else begin
          MemRead  = (ctrl_q.kind == K_LD);
          MemWrite = (ctrl_q.kind != K_LD);
          wait_d   = WAIT_W'(wait_q + 1'b1);
        end
      end
      WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: begin
        // FETCH, and any unreachable encoding behaves as FETCH.
        state_d = FETCH;
        if (imem_ready) begin
          imem_req = 1'b1;
          ir_write = 1'b1;
          ctrl_d   = decode(instr_in[INSTR_W-1 -: OP_W]);
          state_d  = DECODE;
        end else if (wait_hit_c) begin
          bus_err = 1'b1;
        end else begin
          imem_req = 1'b1;
          wait_d   = WAIT_W'(wait_q + 1'b1);
        end
      end
    endcase
    // Reset holds the fetch handshake quiet while state is forced to FETCH.
    if (!rst_n) begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      bus_err  = 1'b0;
    end
    retired_d = CNT_W'(retired_q + CNT_W'(pc_write));
  end

  // State, control, wait and retire registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state         = state_q;
  assign retired_count = retired_q;
  assign Reg2Loc       = ctrl_q.reg2loc;
  assign Uncondbranch  = ctrl_q.uncond;
  assign Branch        = ctrl_q.branch;
  assign MemtoReg      = ctrl_q.memtoreg;
  assign ALUSrc        = ctrl_q.alusrc;
  assign MOVKop        = ctrl_q.movkop;
  assign ALUOp         = ctrl_q.aluop;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width; opcode field is instr[INSTR_W-1 -: 11].
REQ-002 SHALL have parameter ALUOP_W, default 4, ALUOp width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max wait cycles for memory ready (1..255).
REQ-004 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-005 Ports SHALL be (one clock; reset is asynchronous and active-low):
 clk  in  1  rising-edge clock
 rst_n  in  1  asynchronous active-low reset
 instr_in  in  INSTR_W  instruction memory read data
 imem_ready  in  1  instruction fetch complete
 dmem_ready  in  1  data access complete
 zero  in  1  ALU zero flag
 imem_req  out  1  fetch request
 ir_write  out  1  latch instr_in into IR
 Reg2Loc, Uncondbranch, Branch, MemtoReg, ALUSrc, MOVKop  out  1 each  decoded datapath controls
 MemRead, MemWrite, RegWrite  out  1 each  phase-gated strobes
 ALUOp  out  ALUOP_W  ALU operation
 pc_write  out  1  PC update strobe
 illegal  out  1  unknown-opcode pulse
 bus_err  out  1  memory-timeout pulse
 retired_count  out  CNT_W  instructions completed
 state  out  3  FSM state

Function
REQ-006 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; others decode to FETCH.
REQ-007 FETCH: imem_req=1; on imem_ready in same cycle, ir_write=1 and go DECODE; else stay.
REQ-008 DECODE: decode IR opcode; decoded controls SHALL be registered and held constant until the next FETCH exit.
REQ-009 Opcodes (11-bit): B 000101xxxxx, AND 10001010000, ADD 10001011000, ORR 10101010000, CBZ 10110100xxx, SUB 11001011000, MOVK 111100101xx, STUR 11111000000, LDUR 11111000010.
REQ-010 ALUOp SHALL be AND 0000, ORR 0001, ADD/LDUR/STUR 0010, SUB 0110, CBZ 0111, MOVK 1000, B 0000.
REQ-011 ALUSrc=1 for LDUR/STUR/MOVK; Reg2Loc=1 for STUR/CBZ; MemtoReg=1 for LDUR; Uncondbranch=1 for B; Branch=1 for CBZ; MOVKop=1 for MOVK; otherwise 0.
REQ-012 Unknown opcode: illegal=1 for one cycle in DECODE, no strobes, no pc_write, next state FETCH, retired_count unchanged.
REQ-013 EXEC transitions: LDUR/STUR -> MEM; R-type/MOVK -> WB; B/CBZ -> FETCH with pc_write=1 in EXEC (PC source via Uncondbranch | Branch&zero, external).
REQ-014 MEM: MemRead=1 (LDUR) or MemWrite=1 (STUR) while waiting; on dmem_ready, LDUR -> WB, STUR -> FETCH with pc_write=1.
REQ-015 WB: RegWrite=1 and pc_write=1 for exactly one cycle, then FETCH.
REQ-016 retired_count SHALL increment by 1 on every pc_write cycle, wrapping modulo 2^CNT_W.
REQ-017 Zero-wait latency SHALL be: B/CBZ 3 cycles, R-type/MOVK/STUR 4, LDUR 5.
REQ-018 Wait counter SHALL reset on entry to FETCH/MEM; if ready not seen after TIMEOUT wait cycles, bus_err=1 for one cycle, all strobes 0, no pc_write, next state FETCH.
REQ-019 Ready arriving in the same cycle the count reaches TIMEOUT SHALL be accepted as success (no bus_err).
REQ-020 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.

Reset
REQ-021 rst_n=0 SHALL immediately force state=FETCH, all outputs 0 except imem_req, retired_count=0, IR=0, wait counter=0, regardless of current state.
REQ-022 imem_req SHALL be 0 during reset and 1 in the first cycle after rst_n rises.
REQ-023 Reset mid-MEM or mid-WB SHALL suppress any pending MemWrite/RegWrite/pc_write.

Verification
REQ-024 ADD 0x8B000000, ready always 1 -> states 0,1,2,4; RegWrite and pc_write high in cycle 4 only; ALUOp=0010; retired_count=1.
REQ-025 LDUR 0xF8400000, dmem_ready delayed 3 cycles -> MemRead high 4 cycles in MEM, MemtoReg=1, ALUSrc=1, RegWrite in WB; total 8 cycles.
REQ-026 CBZ 0xB4000000 with zero=1 -> Branch=1, Reg2Loc=1, ALUOp=0111, pc_write in EXEC; 3 cycles, no RegWrite.
REQ-027 Opcode 0x00000000 -> illegal pulse in DECODE, return to FETCH, retired_count unchanged.
REQ-028 STUR 0xF8000000, dmem_ready never asserted, TIMEOUT=15 -> MemWrite high 15 cycles, bus_err one-cycle pulse, no pc_write, FETCH next.
REQ-029 rst_n low during WB of MOVK 0xF2C00000 -> RegWrite/pc_write drop same instant, retired_count=0, imem_req=1 first cycle after release.
